// File: rtl/xy_router_param.sv
// 5-port XY mesh router: per-input FIFOs, wormhole locking,
// round-robin arbitration on each free output.
module xy_router_param #(
  parameter int FLIT_W  = 32,
  parameter int COORD_W = 2,
  parameter int DEPTH   = 4,
  localparam int AW     = $clog2(DEPTH),
  localparam int CNT_W  = AW + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [COORD_W-1:0]   routeridx,
  input  logic [COORD_W-1:0]   routeridy,
  input  logic [5*FLIT_W-1:0]  in_flit,
  input  logic [4:0]           push,
  output logic [4:0]           full,
  output logic [5*CNT_W-1:0]   count_out,
  output logic [5*FLIT_W-1:0]  out_flit,
  output logic [4:0]           out_valid,
  input  logic [4:0]           out_ready
);

  logic [FLIT_W-1:0] mem_q [5][DEPTH];
  logic [AW-1:0]     wr_q [5];
  logic [AW-1:0]     rd_q [5];
  logic [CNT_W-1:0]  cnt_q [5];
  logic [4:0]        lock_v_q;
  logic [2:0]        lock_s_q [5];
  logic [2:0]        rr_q [5];

  logic [FLIT_W-1:0] hd [5];
  logic [2:0]        dir [5];
  logic [4:0]        req [5];
  logic [2:0]        gnt_s [5];
  logic [1:0]        otyp [5];
  logic [4:0]        nempty, locksrc, disc;
  logic [4:0]        acc, pop, gnt_v, xfer;

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      hd[i]     = mem_q[i][rd_q[i]];
      nempty[i] = cnt_q[i] != '0;
      full[i]   = cnt_q[i] == CNT_W'(DEPTH);
      count_out[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

  // 0=local 1=north 2=south 3=east 4=west
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      if (hd[i][FLIT_W-3 -: COORD_W] > routeridx)
        dir[i] = 3'd3;
      else if (hd[i][FLIT_W-3 -: COORD_W] < routeridx)
        dir[i] = 3'd4;
      else if (hd[i][FLIT_W-3-COORD_W -: COORD_W] > routeridy)
        dir[i] = 3'd1;
      else if (hd[i][FLIT_W-3-COORD_W -: COORD_W] < routeridy)
        dir[i] = 3'd2;
      else
        dir[i] = 3'd0;
    end
  end

  always_comb begin
    locksrc = '0;
    for (int o = 0; o < 5; o++)
      if (lock_v_q[o]) locksrc[lock_s_q[o]] = 1'b1;
  end

  always_comb begin
    for (int i = 0; i < 5; i++)
      disc[i] = enable & nempty[i] & hd[i][FLIT_W-1] & ~locksrc[i];
    for (int o = 0; o < 5; o++)
      for (int i = 0; i < 5; i++)
        req[o][i] = nempty[i] & ~hd[i][FLIT_W-1] & ~locksrc[i]
                  & (dir[i] == 3'(o));
  end

  always_comb begin : arb
    logic [2:0] ix;
    ix = '0;
    for (int o = 0; o < 5; o++) begin
      gnt_v[o] = 1'b0;
      gnt_s[o] = '0;
      if (lock_v_q[o]) begin
        gnt_v[o] = 1'b1;
        gnt_s[o] = lock_s_q[o];
      end else begin
        for (int k = 1; k <= 5; k++) begin
          ix = 3'((int'(rr_q[o]) + k) % 5);
          if (!gnt_v[o] && req[o][ix]) begin
            gnt_v[o] = 1'b1;
            gnt_s[o] = ix;
          end
        end
      end
    end
  end

  always_comb begin
    pop = disc;
    for (int o = 0; o < 5; o++) begin
      out_valid[o] = enable & gnt_v[o] & nempty[gnt_s[o]];
      out_flit[o*FLIT_W +: FLIT_W] =
        out_valid[o] ? hd[gnt_s[o]] : '0;
      otyp[o]  = hd[gnt_s[o]][FLIT_W-1 -: 2];
      xfer[o]  = out_valid[o] & out_ready[o];
      if (xfer[o]) pop[gnt_s[o]] = 1'b1;
    end
  end

  assign acc = push & ~full & {5{enable & ~reset}};

  always_ff @(posedge clk) begin
    for (int i = 0; i < 5; i++)
      if (acc[i]) mem_q[i][wr_q[i]] <= in_flit[i*FLIT_W +: FLIT_W];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_v_q <= '0;
      for (int i = 0; i < 5; i++) begin
        wr_q[i]     <= '0;
        rd_q[i]     <= '0;
        cnt_q[i]    <= '0;
        lock_s_q[i] <= '0;
        rr_q[i]     <= 3'd4;
      end
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (acc[i]) wr_q[i] <= wr_q[i] + 1'b1;
        if (pop[i]) rd_q[i] <= rd_q[i] + 1'b1;
        cnt_q[i] <= cnt_q[i] + CNT_W'(acc[i]) - CNT_W'(pop[i]);
      end
      for (int o = 0; o < 5; o++) begin
        if (xfer[o]) begin
          if (!lock_v_q[o]) rr_q[o] <= gnt_s[o];
          // head locks, body keeps, tail/single release
          unique case (otyp[o])
            2'b00: begin
              lock_v_q[o] <= 1'b1;
              lock_s_q[o] <= gnt_s[o];
            end
            2'b10:   lock_v_q[o] <= lock_v_q[o];
            default: lock_v_q[o] <= 1'b0;
          endcase
        end
      end
    end
  end

endmodule
